// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch-stage PC/nPC sequencer: redirect kinds,
// branch condition constants and the sequencer state enum.
package fetch_pkg;

    typedef enum logic [1:0] {
        RK_BRANCH = 2'b00,
        RK_CALL   = 2'b01,
        RK_JMPL   = 2'b10,
        RK_RSVD   = 2'b11
    } redirect_kind_e;

    localparam logic [3:0] COND_ALWAYS = 4'b1000;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        SQUASH = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational control-transfer target generation for branch, call and jmpl.
import fetch_pkg::*;

module fetch_target_calc (
    input  logic [1:0]  kind,
    input  logic [31:0] pc_id,
    input  logic [21:0] disp22,
    input  logic [29:0] disp30,
    input  logic [31:0] jmpl_target,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target     = '0;
        misaligned = 1'b0;
        case (redirect_kind_e'(kind))
            RK_BRANCH: target = pc_id + {{8{disp22[21]}}, disp22, 2'b00};
            RK_CALL:   target = pc_id + {disp30, 2'b00};
            RK_JMPL: begin
                // Low bits are forced to zero; the misalignment is only reported.
                target     = {jmpl_target[31:2], 2'b00};
                misaligned = |jmpl_target[1:0];
            end
            default:   target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC/nPC sequencer with delayed control transfer, delay-slot
// annulment, stall hold and a one-bubble boot sequence.
import fetch_pkg::*;

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             le,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_kind,
    input  logic             branch_taken,
    input  logic [3:0]       cond,
    input  logic             annul_bit,
    input  logic [31:0]      pc_id,
    input  logic [21:0]      disp22,
    input  logic [29:0]      disp30,
    input  logic [31:0]      jmpl_target,
    output logic [31:0]      pc_out,
    output logic [31:0]      npc_out,
    output logic             fetch_valid,
    output logic             squash_id,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      npc_q, npc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;

    logic [31:0]      target;
    logic             misaligned;
    redirect_kind_e   kind;

    assign kind = redirect_kind_e'(redirect_kind);

    fetch_target_calc u_target_calc (
        .kind        (redirect_kind),
        .pc_id       (pc_id),
        .disp22      (disp22),
        .disp30      (disp30),
        .jmpl_target (jmpl_target),
        .target      (target),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        if (le) begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN, SQUASH: begin
                    pc_d    = npc_q;
                    npc_d   = npc_q + 32'd4;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = RUN;
                    // In SQUASH the ID instruction is being flushed, so its request is dropped.
                    if (state_q == RUN && redirect_valid && kind != RK_RSVD) begin
                        if (kind != RK_BRANCH || branch_taken) begin
                            npc_d = target;
                        end
                        if (kind == RK_BRANCH && annul_bit &&
                            (!branch_taken || cond == COND_ALWAYS)) begin
                            state_d = SQUASH;
                        end
                        if (misaligned) begin
                            mis_d = 1'b1;
                        end
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_out       = pc_q;
    assign npc_out      = npc_q;
    assign fetch_valid  = (state_q != BOOT);
    assign squash_id    = (state_q == SQUASH);
    assign misalign_err = mis_q;
    assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written async-reset
// sequence, then randomized traffic against a fetch-stream reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        le;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic        branch_taken;
    logic [3:0]  cond;
    logic        annul_bit;
    logic [31:0] pc_id;
    logic [21:0] disp22;
    logic [29:0] disp30;
    logic [31:0] jmpl_target;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        fetch_valid;
    logic        squash_id;
    logic        misalign_err;
    logic [15:0] fetch_count;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .clr            (clr),
        .le             (le),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .branch_taken   (branch_taken),
        .cond           (cond),
        .annul_bit      (annul_bit),
        .pc_id          (pc_id),
        .disp22         (disp22),
        .disp30         (disp30),
        .jmpl_target    (jmpl_target),
        .pc_out         (pc_out),
        .npc_out        (npc_out),
        .fetch_valid    (fetch_valid),
        .squash_id      (squash_id),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic [31:0] enpc,
                           input logic efv, input logic esq, input logic emis,
                           input logic [31:0] ecnt);
        chk({tag, ".pc"},    pc_out, epc);
        chk({tag, ".npc"},   npc_out, enpc);
        chk({tag, ".fv"},    32'(fetch_valid), 32'(efv));
        chk({tag, ".sq"},    32'(squash_id), 32'(esq));
        chk({tag, ".mis"},   32'(misalign_err), 32'(emis));
        chk({tag, ".cnt"},   32'(fetch_count), ecnt);
    endtask

    typedef struct {
        logic        le;
        logic        rv;
        logic [1:0]  kind;
        logic        tk;
        logic [3:0]  cnd;
        logic        a;
        logic [31:0] pcid;
        logic [21:0] d22;
        logic [29:0] d30;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic        e_fv;
        logic        e_sq;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic l, logic rv, logic [1:0] k, logic tk, logic [3:0] c,
                                logic a, logic [31:0] pcid, logic [21:0] d22,
                                logic [29:0] d30, logic [31:0] jt,
                                logic [31:0] epc, logic [31:0] enpc, logic efv,
                                logic esq, logic emis, logic [31:0] ecnt);
        vec_t v;
        v.le = l; v.rv = rv; v.kind = k; v.tk = tk; v.cnd = c; v.a = a;
        v.pcid = pcid; v.d22 = d22; v.d30 = d30; v.jt = jt;
        v.e_pc = epc; v.e_npc = enpc; v.e_fv = efv; v.e_sq = esq;
        v.e_mis = emis; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic drive(input logic l, input logic rv, input logic [1:0] k, input logic tk,
                         input logic [3:0] c, input logic a, input logic [31:0] pcid,
                         input logic [21:0] d22, input logic [29:0] d30, input logic [31:0] jt);
        le = l; redirect_valid = rv; redirect_kind = k; branch_taken = tk;
        cond = c; annul_bit = a; pc_id = pcid; disp22 = d22; disp30 = d30;
        jmpl_target = jt;
    endtask

    // Reference model: the fetch stream as a (pc, npc) pair plus the facts
    // "still in the boot bubble" and "the instruction now in ID is annulled".
    logic [31:0] m_pc, m_npc;
    bit          m_boot, m_annulled, m_mis;
    int unsigned m_cnt;

    function automatic void model_reset();
        m_pc = 32'h0; m_npc = 32'h4; m_boot = 1; m_annulled = 0; m_mis = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge();
        logic [31:0] tgt;
        bit take, annul_next;
        if (!le) return;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        m_cnt      = (m_cnt + 1) % 65536;
        take       = 0;
        annul_next = 0;
        tgt        = 32'h0;
        if (!m_annulled && redirect_valid && redirect_kind != 2'b11) begin
            case (redirect_kind)
                2'b00: begin
                    tgt  = pc_id + 32'($signed(disp22)) * 4;
                    take = branch_taken;
                    annul_next = annul_bit && (!branch_taken || cond == 4'b1000);
                end
                2'b01: begin
                    tgt  = pc_id + {2'b00, disp30} * 4;
                    take = 1;
                end
                default: begin
                    tgt  = jmpl_target - (jmpl_target % 4);
                    take = 1;
                    if (jmpl_target % 4 != 0) m_mis = 1;
                end
            endcase
        end
        m_pc       = m_npc;
        m_npc      = take ? tgt : m_npc + 32'd4;
        m_annulled = annul_next;
    endfunction

    localparam logic [1:0] KB = 2'b00, KC = 2'b01, KJ = 2'b10, KR = 2'b11;

    vec_t vecs[25];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h0,   32'h4,   1,0,0,0);
        vecs[1]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h4,   32'h8,   1,0,0,1);
        vecs[2]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h8,   32'hC,   1,0,0,2);
        vecs[3]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'hC,   32'h10,  1,0,0,3);
        vecs[4]  = mk(1,1,KB,1,0,0, 8,22'h10,0,0,         32'h10,  32'h48,  1,0,0,4);
        vecs[5]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h48,  32'h4C,  1,0,0,5);
        vecs[6]  = mk(1,1,KB,0,0,1, 8,22'h10,0,0,         32'h4C,  32'h50,  1,1,0,6);
        vecs[7]  = mk(1,1,KC,0,0,0, 8,0,30'h3FFFFFFF,0,   32'h50,  32'h54,  1,0,0,7);
        vecs[8]  = mk(1,1,KB,1,4'b1000,1, 8,22'h10,0,0,   32'h54,  32'h48,  1,1,0,8);
        vecs[9]  = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h48,  32'h4C,  1,0,0,9);
        vecs[10] = mk(1,1,KC,0,0,0, 8,0,30'h3FFFFFFF,0,   32'h4C,  32'h4,   1,0,0,10);
        vecs[11] = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h4,   32'h8,   1,0,0,11);
        vecs[12] = mk(1,1,KR,1,0,0, 8,22'h10,0,32'h500,   32'h8,   32'hC,   1,0,0,12);
        vecs[13] = mk(1,1,KB,0,0,0, 8,22'h10,0,0,         32'hC,   32'h10,  1,0,0,13);
        vecs[14] = mk(0,1,KJ,0,0,0, 0,0,0,32'h103,        32'hC,   32'h10,  1,0,0,13);
        vecs[15] = mk(0,1,KJ,0,0,0, 0,0,0,32'h103,        32'hC,   32'h10,  1,0,0,13);
        vecs[16] = mk(0,1,KJ,0,0,0, 0,0,0,32'h103,        32'hC,   32'h10,  1,0,0,13);
        vecs[17] = mk(1,1,KJ,0,0,0, 0,0,0,32'h103,        32'h10,  32'h100, 1,0,1,14);
        vecs[18] = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h100, 32'h104, 1,0,1,15);
        vecs[19] = mk(1,1,KJ,0,0,0, 0,0,0,32'h200,        32'h104, 32'h200, 1,0,1,16);
        vecs[20] = mk(1,1,KB,0,0,1, 8,22'h10,0,0,         32'h200, 32'h204, 1,1,1,17);
        vecs[21] = mk(0,0,KB,0,0,0, 0,0,0,0,              32'h200, 32'h204, 1,1,1,17);
        vecs[22] = mk(1,0,KB,0,0,0, 0,0,0,0,              32'h204, 32'h208, 1,0,1,18);
        vecs[23] = mk(1,1,KB,1,0,0, 32'h1000,22'h3FFFFF,0,0, 32'h208, 32'hFFC, 1,0,1,19);
        vecs[24] = mk(1,0,KB,0,0,0, 0,0,0,0,              32'hFFC, 32'h1000,1,0,1,20);

        // Reset and the boot bubble.
        clr = 1'b0;
        drive(1,0,KB,0,0,0,0,0,0,0);
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk_all("boot", 32'h0, 32'h4, 0, 0, 0, 0);

        for (int unsigned i = 0; i < 25; i++) begin
            drive(vecs[i].le, vecs[i].rv, vecs[i].kind, vecs[i].tk, vecs[i].cnd, vecs[i].a,
                  vecs[i].pcid, vecs[i].d22, vecs[i].d30, vecs[i].jt);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_fv,
                    vecs[i].e_sq, vecs[i].e_mis, vecs[i].e_cnt);
        end

        // Asynchronous reset while the delay slot is being squashed.
        drive(1,1,KB,0,0,1,8,22'h10,0,0);
        @(posedge clk);
        #1;
        chk("sqpre.sq", 32'(squash_id), 32'h1);
        drive(1,0,KB,0,0,0,0,0,0,0);
        #2;
        clr = 1'b0;
        #1;
        chk_all("sqrst", 32'h0, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b1;
        model_reset();

        // Randomized traffic, with occasional asynchronous resets.
        for (int unsigned i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1), $urandom, 22'($urandom), 30'($urandom),
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            @(posedge clk);
            model_edge();
            #1;
            chk_all("rand", m_pc, m_npc, !m_boot, m_annulled, m_mis, m_cnt);
            if ($urandom_range(0, 249) == 0) begin
                #2;
                clr = 1'b0;
                model_reset();
                #1;
                chk_all("rrst", m_pc, m_npc, !m_boot, m_annulled, m_mis, m_cnt);
                @(negedge clk);
                clr = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
